// File: rtl/ulaw_topk_argmax_if.sv
// Score/result bundle for the top-2 classifier stage.
// The master drives the scores and the start/clear controls; the slave reports the result.
interface ulaw_topk_argmax_if #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int IDX_W       = $clog2(NUM_CLASSES + 1)
);
   logic                              start;
   logic                              clear;
   logic [NUM_CLASSES*DATA_WIDTH-1:0] scores;
   logic                              busy;
   logic                              done;
   logic [IDX_W-1:0]                  max_idx;
   logic [DATA_WIDTH-1:0]             max_val;
   logic [IDX_W-1:0]                  second_idx;
   logic [DATA_WIDTH-1:0]             second_val;
   logic [DATA_WIDTH-1:0]             margin;
   logic                              tie;

   modport master (
      output start, clear, scores,
      input  busy, done, max_idx, max_val, second_idx, second_val, margin, tie
   );

   modport slave (
      input  start, clear, scores,
      output busy, done, max_idx, max_val, second_idx, second_val, margin, tie
   );
endinterface

// File: rtl/ulaw_topk_argmax.sv
// Sequential argmax / runner-up classifier. Captures all class scores on start,
// scans one class per cycle with an encoding-aware ordering key, and reports the
// best class, the runner-up and the key margin between them.
module ulaw_topk_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int MODE        = 1,
   parameter int IDX_BASE    = 1,
   parameter int IDX_W       = $clog2(NUM_CLASSES + IDX_BASE)
) (
   input logic               clk,
   input logic               rst,
   ulaw_topk_argmax_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_CLASSES);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                state_q, state_d;
   logic                  accept, last;
   logic [CNT_W-1:0]      cnt_q;

   logic [DATA_WIDTH-1:0] scores_p0 [NUM_CLASSES];
   logic [DATA_WIDTH-1:0] elem_val, elem_key;

   logic [DATA_WIDTH-1:0] best_key_p1, best_val_p1, sec_key_p1, sec_val_p1;
   logic [CNT_W-1:0]      best_idx_p1, sec_idx_p1;
   logic                  sec_vld_p1;

   logic [DATA_WIDTH-1:0] nb_key, nb_val, ns_key, ns_val;
   logic [CNT_W-1:0]      nb_idx, ns_idx;
   logic                  ns_vld;

   // Map an encoded score onto an unsigned key whose natural order is the value order.
   // Mu-law: negatives (inverted MSB set) fold below positives, so -0 sits just under +0.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] t;
      if (MODE == 0) return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
      t = ~s;
      if (!t[DATA_WIDTH-1]) return {1'b1, t[DATA_WIDTH-2:0]};
      return {1'b0, ~t[DATA_WIDTH-2:0]};
   endfunction

   // Scan position plus label offset, truncated to the index width.
   function automatic logic [IDX_W-1:0] label(input logic [CNT_W-1:0] c);
      return IDX_W'(c) + IDX_W'(IDX_BASE);
   endfunction

   // State register and scan counter; clear behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)              cnt_q <= '0;
         else if (state_q == SCAN) cnt_q <= cnt_q + 1'b1;
      end
   end

   // Next state: start is honoured in IDLE and DONE only, never mid-scan.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (cnt_q == CNT_W'(NUM_CLASSES - 1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign elem_val = scores_p0[cnt_q];
   assign elem_key = order_key(elem_val);

   // Running top-2 update for the element under the scan pointer; strict compares keep the first occurrence as best.
   always_comb begin
      nb_key = best_key_p1;
      nb_val = best_val_p1;
      nb_idx = best_idx_p1;
      ns_key = sec_key_p1;
      ns_val = sec_val_p1;
      ns_idx = sec_idx_p1;
      ns_vld = sec_vld_p1;
      if (cnt_q == '0) begin
         nb_key = elem_key;
         nb_val = elem_val;
         nb_idx = cnt_q;
         ns_vld = 1'b0;
      end else if (elem_key > best_key_p1) begin
         ns_key = best_key_p1;
         ns_val = best_val_p1;
         ns_idx = best_idx_p1;
         ns_vld = 1'b1;
         nb_key = elem_key;
         nb_val = elem_val;
         nb_idx = cnt_q;
      end else if (!sec_vld_p1 || (elem_key > sec_key_p1)) begin
         ns_key = elem_key;
         ns_val = elem_val;
         ns_idx = cnt_q;
         ns_vld = 1'b1;
      end
   end

   // Stage p0 captures the score vector; stage p1 holds the running best/second while scanning.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            scores_p0[i] <= bus.scores[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (state_q == SCAN) begin
         best_key_p1 <= nb_key;
         best_val_p1 <= nb_val;
         best_idx_p1 <= nb_idx;
         sec_key_p1  <= ns_key;
         sec_val_p1  <= ns_val;
         sec_idx_p1  <= ns_idx;
         sec_vld_p1  <= ns_vld;
      end
   end

   // Result registers: zero while idle or scanning, loaded on the final scan edge and held in DONE.
   always_ff @(posedge clk) begin
      if (rst || bus.clear || accept) begin
         bus.busy       <= accept && !(rst || bus.clear);
         bus.done       <= 1'b0;
         bus.max_idx    <= '0;
         bus.max_val    <= '0;
         bus.second_idx <= '0;
         bus.second_val <= '0;
         bus.margin     <= '0;
         bus.tie        <= 1'b0;
      end else if (last) begin
         bus.busy       <= 1'b0;
         bus.done       <= 1'b1;
         bus.max_idx    <= label(nb_idx);
         bus.max_val    <= nb_val;
         bus.second_idx <= label(ns_idx);
         bus.second_val <= ns_val;
         bus.margin     <= nb_key - ns_key;
         bus.tie        <= (nb_key == ns_key);
      end
   end
endmodule

// File: tb/tb_ulaw_topk_argmax.sv
// Bench for ulaw_topk_argmax: one two's-complement instance and one mu-law instance,
// each compared every cycle against a transaction-level reference, plus literal result pins.
module tb_ulaw_topk_argmax;
   localparam int NC = 10;
   localparam int DW = 8;
   localparam int IB = 1;
   localparam int IW = $clog2(NC + IB);

   typedef logic [DW-1:0] vec_t [NC];
   typedef struct packed {
      logic [IW-1:0] mi;
      logic [DW-1:0] mv;
      logic [IW-1:0] si;
      logic [DW-1:0] sv;
      logic [DW-1:0] mg;
      logic          tie;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic st [2];
   logic cl [2];
   vec_t sc [2];

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;

   always #5 clk = ~clk;

   ulaw_topk_argmax_if #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_W(IW)) bus0 ();
   ulaw_topk_argmax_if #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_W(IW)) bus1 ();

   ulaw_topk_argmax #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .MODE(0), .IDX_BASE(IB), .IDX_W(IW))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   ulaw_topk_argmax #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .MODE(1), .IDX_BASE(IB), .IDX_W(IW))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   function automatic logic [NC*DW-1:0] pack(input vec_t a);
      logic [NC*DW-1:0] f;
      for (int i = 0; i < NC; i++) f[i*DW +: DW] = a[i];
      return f;
   endfunction

   assign bus0.start  = st[0];
   assign bus0.clear  = cl[0];
   assign bus0.scores = pack(sc[0]);
   assign bus1.start  = st[1];
   assign bus1.clear  = cl[1];
   assign bus1.scores = pack(sc[1]);

   logic          o_busy [2];
   logic          o_done [2];
   logic          o_tie  [2];
   logic [IW-1:0] o_mi   [2];
   logic [IW-1:0] o_si   [2];
   logic [DW-1:0] o_mv   [2];
   logic [DW-1:0] o_sv   [2];
   logic [DW-1:0] o_mg   [2];

   assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
   assign o_done[0] = bus0.done;       assign o_done[1] = bus1.done;
   assign o_tie[0]  = bus0.tie;        assign o_tie[1]  = bus1.tie;
   assign o_mi[0]   = bus0.max_idx;    assign o_mi[1]   = bus1.max_idx;
   assign o_si[0]   = bus0.second_idx; assign o_si[1]   = bus1.second_idx;
   assign o_mv[0]   = bus0.max_val;    assign o_mv[1]   = bus1.max_val;
   assign o_sv[0]   = bus0.second_val; assign o_sv[1]   = bus1.second_val;
   assign o_mg[0]   = bus0.margin;     assign o_mg[1]   = bus1.margin;

   // Numeric ordering value of an encoded score (instance 0: two's complement, 1: mu-law).
   function automatic int key_of(input int mode, input logic [DW-1:0] s);
      int mag;
      if (mode == 0) return int'($signed(s)) + 128;
      mag = 127 - int'(s[DW-2:0]);
      return s[DW-1] ? (128 + mag) : (127 - mag);
   endfunction

   // Best = first index holding the largest key; second = earliest of the rest with the largest key.
   function automatic res_t ref_result(input int mode, input vec_t a);
      int   k [NC];
      int   b;
      int   s;
      res_t r;
      for (int i = 0; i < NC; i++) k[i] = key_of(mode, a[i]);
      b = 0;
      for (int i = 1; i < NC; i++) if (k[i] > k[b]) b = i;
      s = -1;
      for (int i = 0; i < NC; i++) if (i != b && (s < 0 || k[i] > k[s])) s = i;
      r.mi  = IW'(b + IB);
      r.mv  = a[b];
      r.si  = IW'(s + IB);
      r.sv  = a[s];
      r.mg  = DW'(k[b] - k[s]);
      r.tie = (k[b] == k[s]);
      return r;
   endfunction

   bit   m_busy [2];
   bit   m_done [2];
   int   m_left [2];
   res_t m_out  [2];
   res_t m_pend [2];

   // Transaction-level reference: result computed at capture, revealed NC edges later.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst || cl[m]) begin
            m_busy[m] = 1'b0; m_done[m] = 1'b0; m_out[m] = '0; m_left[m] = 0;
         end else if (!m_busy[m] && st[m]) begin
            m_pend[m] = ref_result(m, sc[m]);
            m_busy[m] = 1'b1; m_done[m] = 1'b0; m_out[m] = '0; m_left[m] = NC;
         end else if (m_busy[m]) begin
            m_left[m] = m_left[m] - 1;
            if (m_left[m] == 0) begin
               m_busy[m] = 1'b0; m_done[m] = 1'b1; m_out[m] = m_pend[m];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of both instances against the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_busy", m),       32'(o_busy[m]), 32'(m_busy[m]));
            chk($sformatf("m%0d_done", m),       32'(o_done[m]), 32'(m_done[m]));
            chk($sformatf("m%0d_max_idx", m),    32'(o_mi[m]),   32'(m_out[m].mi));
            chk($sformatf("m%0d_max_val", m),    32'(o_mv[m]),   32'(m_out[m].mv));
            chk($sformatf("m%0d_second_idx", m), 32'(o_si[m]),  32'(m_out[m].si));
            chk($sformatf("m%0d_second_val", m), 32'(o_sv[m]),  32'(m_out[m].sv));
            chk($sformatf("m%0d_margin", m),     32'(o_mg[m]),   32'(m_out[m].mg));
            chk($sformatf("m%0d_tie", m),        32'(o_tie[m]),  32'(m_out[m].tie));
         end
      end
   end

   task automatic lit(input string name, input int m, input int mi, input int mv,
                      input int si, input int sv, input int mg, input int tie);
      chk({name, "_done"},       32'(o_done[m]), 1);
      chk({name, "_max_idx"},    32'(o_mi[m]),   mi);
      chk({name, "_max_val"},    32'(o_mv[m]),   mv);
      chk({name, "_second_idx"}, 32'(o_si[m]),   si);
      chk({name, "_second_val"}, 32'(o_sv[m]),   sv);
      chk({name, "_margin"},     32'(o_mg[m]),   mg);
      chk({name, "_tie"},        32'(o_tie[m]),  tie);
   endtask

   // Pulse start, optionally inject start/clear/rst at edge inj_at (kind 1/2/3), report first done edge.
   task automatic run_scan(input int m, input int inj_at, input int kind, input bit scram, output int lat);
      lat = -1;
      @(negedge clk);
      st[m] = 1'b1;
      @(negedge clk);
      st[m] = 1'b0;
      chk("start_busy", 32'(o_busy[m]), 1);
      chk("start_done_low", 32'(o_done[m]), 0);
      for (int n = 1; n <= 3 * NC; n++) begin
         if (n == inj_at) begin
            case (kind)
               1: st[m] = 1'b1;
               2: cl[m] = 1'b1;
               3: rst   = 1'b1;
               default: ;
            endcase
         end
         if (scram && n == 4) for (int i = 0; i < NC; i++) sc[m][i] = 8'($urandom);
         @(negedge clk);
         st[m] = 1'b0;
         cl[m] = 1'b0;
         rst   = 1'b0;
         if (n == inj_at && kind >= 2) begin
            chk("abort_busy", 32'(o_busy[m]), 0);
            chk("abort_done", 32'(o_done[m]), 0);
            chk("abort_max_val", 32'(o_mv[m]), 0);
            chk("abort_margin", 32'(o_mg[m]), 0);
         end
         if (o_done[m] === 1'b1 && lat < 0) lat = n;
      end
   endtask

   task automatic set_t1(input int m);
      for (int i = 0; i < NC; i++) sc[m][i] = 8'hFF;
      sc[m][6] = 8'h80;
   endtask

   task automatic set_t2(input int m);
      for (int i = 0; i < NC; i++) sc[m][i] = 8'hFF;
      sc[m][2] = 8'h90;
      sc[m][5] = 8'h90;
   endtask

   logic [DW-1:0] pool [5] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h90};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int m;
      int kind;
      int inj;
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0;
         cl[k] = 1'b0;
         for (int i = 0; i < NC; i++) sc[k][i] = 8'($urandom);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 32'(o_busy[1]), 0);
      chk("rst_done", 32'(o_done[1]), 0);
      chk("rst_max_idx", 32'(o_mi[1]), 0);
      chk("rst_margin", 32'(o_mg[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // Single positive winner among +0 scores.
      set_t1(1);
      run_scan(1, 0, 0, 1'b0, lat);
      chk("t1_latency", lat, NC);
      lit("t1", 1, 7, 8'h80, 1, 8'hFF, 8'h7F, 0);

      // Equal winners: first occurrence is best, second ties it.
      set_t2(1);
      run_scan(1, 0, 0, 1'b0, lat);
      lit("t2", 1, 3, 8'h90, 6, 8'h90, 0, 1);

      // All-negative mu-law ramp.
      for (int i = 0; i < NC; i++) sc[1][i] = 8'(i);
      run_scan(1, 0, 0, 1'b0, lat);
      lit("t3a", 1, 10, 8'h09, 9, 8'h08, 1, 0);

      // -0 orders below +0.
      for (int i = 0; i < NC; i++) sc[1][i] = 8'h00;
      sc[1][0] = 8'h7F;
      sc[1][1] = 8'hFF;
      run_scan(1, 0, 0, 1'b0, lat);
      lit("t3b", 1, 2, 8'hFF, 1, 8'h7F, 1, 0);

      // Two's-complement ordering.
      for (int i = 0; i < NC; i++) sc[0][i] = 8'h80;
      sc[0][1] = 8'h7F;
      sc[0][2] = 8'h00;
      sc[0][3] = 8'hFF;
      run_scan(0, 0, 0, 1'b0, lat);
      lit("t4", 0, 2, 8'h7F, 3, 8'h00, 8'h7F, 0);

      // Start mid-scan is ignored; clear and rst abort the scan.
      set_t1(1);
      run_scan(1, 3, 1, 1'b0, lat);
      chk("t5_restart_ignored_latency", lat, NC);
      lit("t5a", 1, 7, 8'h80, 1, 8'hFF, 8'h7F, 0);
      run_scan(1, 5, 2, 1'b0, lat);
      chk("t5_clear_no_done", lat, -1);
      run_scan(1, 5, 3, 1'b0, lat);
      chk("t5_rst_no_done", lat, -1);

      // clear wins over a simultaneous start.
      @(negedge clk);
      st[1] = 1'b1;
      cl[1] = 1'b1;
      @(negedge clk);
      st[1] = 1'b0;
      cl[1] = 1'b0;
      chk("t5_clear_start_busy", 32'(o_busy[1]), 0);
      repeat (NC + 2) @(negedge clk);
      chk("t5_clear_start_done", 32'(o_done[1]), 0);

      // DONE holds across score changes; restart from DONE.
      set_t1(1);
      run_scan(1, 0, 0, 1'b0, lat);
      set_t2(1);
      repeat (3) @(negedge clk);
      lit("t6_hold", 1, 7, 8'h80, 1, 8'hFF, 8'h7F, 0);
      run_scan(1, 0, 0, 1'b0, lat);
      chk("t6_latency", lat, NC);
      lit("t6_new", 1, 3, 8'h90, 6, 8'h90, 0, 1);

      // Randomized traffic with ties, mid-scan score changes, stray starts and clears.
      for (int it = 0; it < 200; it++) begin
         m = it % 2;
         for (int i = 0; i < NC; i++)
            sc[m][i] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 4)] : 8'($urandom);
         kind = $urandom_range(0, 9);
         kind = (kind < 6) ? 0 : ((kind < 8) ? 1 : 2);
         inj  = $urandom_range(1, NC + 2);
         run_scan(m, inj, kind, 1'b1, lat);
         if (kind == 2 && inj <= NC) chk("rand_clear_no_done", lat, -1);
         else                        chk("rand_latency", lat, NC);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
